// File: rtl/zbt_port_if.sv
// Bundle of requester and SRAM-pin signals around the ZBT0 port arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/SRAM side.
interface zbt_port_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 36
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              clear_start;
  logic              clear_busy;
  logic [ADDR_W-1:0] zbt_addr;
  logic              zbt_we;
  logic [DATA_W-1:0] zbt_write_data;
  logic [DATA_W-1:0] zbt_read_data;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, clear_start, zbt_read_data,
    output wr_ready, rd_ready, rd_data, rd_valid, clear_busy, zbt_addr, zbt_we, zbt_write_data
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, clear_start, zbt_read_data,
    input  wr_ready, rd_ready, rd_data, rd_valid, clear_busy, zbt_addr, zbt_we, zbt_write_data
  );
endinterface

// File: rtl/zbt_port_arbiter.sv
// Shares the ZBT0 SRAM port between capture writes, renderer reads and a zero-fill engine.
// Define ZBT_READ_PRIORITY_EN to give reads strict priority instead of round-robin.
module zbt_port_arbiter #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 36,
  parameter int RD_LATENCY  = 2,
  parameter int WR_LATENCY  = 2,
  parameter int CLEAR_DEPTH = 2**19
) (
  input  logic       clk,
  input  logic       rst_n,
  zbt_port_if.slave  bus
);
  // state   | meaning
  // S_IDLE  | clear engine off; external writer competes with reads
  // S_CLEAR | zero-filling 0..CLEAR_DEPTH-1; clear writes take the write side
  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} clr_state_t;

  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(CLEAR_DEPTH - 1);

  clr_state_t        r_state, w_state_nxt;
  logic [ADDR_W:0]   r_clr_cnt;
  logic              w_busy, w_ws_req;
  logic              w_gnt_rd, w_gnt_ws, w_gnt_wr, w_gnt_clr;
  logic [ADDR_W-1:0] r_zbt_addr;
  logic              r_zbt_we;
  logic [DATA_W-1:0] r_wd_pipe [WR_LATENCY];
  logic [DATA_W-1:0] r_wd_out;
  logic [RD_LATENCY-1:0] r_rd_tag;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  assign w_busy   = (r_state == S_CLEAR);
  assign w_ws_req = w_busy | bus.wr_req;

`ifdef ZBT_READ_PRIORITY_EN
  assign w_gnt_rd = bus.rd_req;
`else
  logic r_favour_rd;

  // Only contended cycles move the pointer; an uncontested side never waits.
  assign w_gnt_rd = bus.rd_req & (~w_ws_req | r_favour_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_favour_rd <= 1'b1;
    end else if (bus.rd_req && w_ws_req) begin
      r_favour_rd <= ~w_gnt_rd;
    end
  end
`endif

  assign w_gnt_ws  = w_ws_req & ~w_gnt_rd;
  assign w_gnt_wr  = w_gnt_ws & ~w_busy;
  assign w_gnt_clr = w_gnt_ws & w_busy;

  assign bus.rd_ready       = w_gnt_rd;
  assign bus.wr_ready       = w_gnt_wr;
  assign bus.clear_busy     = w_busy;
  assign bus.zbt_addr       = r_zbt_addr;
  assign bus.zbt_we         = r_zbt_we;
  assign bus.zbt_write_data = r_wd_out;
  assign bus.rd_data        = r_rd_data;
  assign bus.rd_valid       = r_rd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.clear_start) w_state_nxt = S_CLEAR;
      S_CLEAR: if (w_gnt_clr && (r_clr_cnt == CLR_LAST)) w_state_nxt = S_IDLE;
    endcase
  end

  // One bit wider than the address so a full-array clear terminates cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_cnt <= '0;
    end else if (!w_busy && bus.clear_start) begin
      r_clr_cnt <= '0;
    end else if (w_gnt_clr) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zbt_addr <= '0;
      r_zbt_we   <= 1'b0;
    end else if (w_gnt_rd) begin
      r_zbt_addr <= bus.rd_addr;
      r_zbt_we   <= 1'b0;
    end else if (w_gnt_wr) begin
      r_zbt_addr <= bus.wr_addr;
      r_zbt_we   <= 1'b1;
    end else if (w_gnt_clr) begin
      r_zbt_addr <= r_clr_cnt[ADDR_W-1:0];
      r_zbt_we   <= 1'b1;
    end else begin
      r_zbt_we   <= 1'b0;
    end
  end

  // Non-write slots carry zero so the data bus idles at 0 and clears write 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WR_LATENCY; i++) r_wd_pipe[i] <= '0;
      r_wd_out <= '0;
    end else begin
      r_wd_pipe[0] <= w_gnt_wr ? bus.wr_data : '0;
      for (int i = 1; i < WR_LATENCY; i++) r_wd_pipe[i] <= r_wd_pipe[i-1];
      r_wd_out <= r_wd_pipe[WR_LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_tag   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_tag[0] <= w_gnt_rd;
      for (int i = 1; i < RD_LATENCY; i++) r_rd_tag[i] <= r_rd_tag[i-1];
      r_rd_valid <= r_rd_tag[RD_LATENCY-1];
      if (r_rd_tag[RD_LATENCY-1]) r_rd_data <= bus.zbt_read_data;
    end
  end
endmodule

// File: tb/tb_zbt_port_arbiter.sv
// Scoreboard bench for zbt_port_arbiter: a spec-level model predicts grants, SRAM issues,
// write-data timing and read returns; a monitor checks them as the DUT presents them.
module tb_zbt_port_arbiter;
  localparam int AW  = 19;
  localparam int DW  = 36;
  localparam int RDL = 2;
  localparam int WRL = 2;
  localparam int CD  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zbt_port_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  zbt_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RDL), .WR_LATENCY(WRL), .CLEAR_DEPTH(CD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct { int cyc; logic we; logic [AW-1:0] addr; } iss_t;
  typedef struct { int cyc; logic [DW-1:0] d; } dat_t;

  iss_t iss_q[$];
  dat_t wd_q[$];
  dat_t rd_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] sram    [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  bit m_last_win_wr = 1'b1;
  bit m_clr = 1'b0;
  int m_clr_next = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  // SRAM: write data arrives WRL edges after its address; read data must be
  // on the pins before the RDL-th edge after its address.
  logic          q1_we = 1'b0, q2_we = 1'b0;
  logic [AW-1:0] q1_addr = '0, q2_addr = '0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      q1_we = 1'b0;
      q2_we = 1'b0;
    end else begin
      if (q2_we) sram[q2_addr] = bus.zbt_write_data;
      if (!q1_we) bus.zbt_read_data = sram.exists(q1_addr) ? sram[q1_addr] : '0;
      q2_we = q1_we; q2_addr = q1_addr;
      q1_we = bus.zbt_we; q1_addr = bus.zbt_addr;
    end
  end

  iss_t mi;
  dat_t md;
  always @(posedge clk) begin
    #2;
    if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
      mi = iss_q.pop_front();
      check("zbt_we", 64'(bus.zbt_we), 64'(mi.we));
      check("zbt_addr", 64'(bus.zbt_addr), 64'(mi.addr));
    end else begin
      check("zbt_we_idle", 64'(bus.zbt_we), 64'(0));
    end
    if (wd_q.size() > 0 && wd_q[0].cyc == cyc) begin
      md = wd_q.pop_front();
      check("zbt_write_data", 64'(bus.zbt_write_data), 64'(md.d));
    end else begin
      check("zbt_write_data_idle", 64'(bus.zbt_write_data), 64'(0));
    end
    if (bus.rd_valid) begin
      if (rd_q.size() == 0) begin
        check("rd_valid_spurious", 64'(bus.rd_valid), 64'(0));
      end else begin
        md = rd_q.pop_front();
        check("rd_valid_cycle", 64'(cyc), 64'(md.cyc));
        check("rd_data", 64'(bus.rd_data), 64'(md.d));
      end
    end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
      md = rd_q.pop_front();
      check("rd_valid_missing", 64'(bus.rd_valid), 64'(1));
    end
  end

  task automatic tick(input logic rq, input logic [AW-1:0] ra, input logic wq,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic cs,
                      output logic ar, output logic aw);
    bit busy, wside, gr, gw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    bus.rd_req = rq; bus.rd_addr = ra;
    bus.wr_req = wq; bus.wr_addr = wa; bus.wr_data = wd;
    bus.clear_start = cs;
    #1;
    busy  = m_clr;
    wside = busy || wq;
`ifdef ZBT_READ_PRIORITY_EN
    gr = rq;
`else
    if (rq && wside) begin
      gr = m_last_win_wr;
      m_last_win_wr = !gr;
    end else begin
      gr = rq;
    end
`endif
    gw = wside && !gr;
    check("rd_ready", 64'(bus.rd_ready), 64'(gr));
    check("wr_ready", 64'(bus.wr_ready), 64'(gw && !busy));
    check("clear_busy", 64'(bus.clear_busy), 64'(busy));
    if (gr) begin
      iss_q.push_back(iss_t'{cyc + 1, 1'b0, ra});
      rd_q.push_back(dat_t'{cyc + 1 + RDL, ref_rd(ra)});
    end else if (gw) begin
      if (busy) begin
        a = m_clr_next[AW-1:0];
        d = '0;
        m_clr_next++;
        if (m_clr_next == CD) m_clr = 1'b0;
      end else begin
        a = wa;
        d = wd;
      end
      ref_mem[a] = d;
      iss_q.push_back(iss_t'{cyc + 1, 1'b1, a});
      wd_q.push_back(dat_t'{cyc + 1 + WRL, d});
    end
    if (cs && !busy) begin
      m_clr = 1'b1;
      m_clr_next = 0;
    end
    ar = rq && bus.rd_ready;
    aw = wq && bus.wr_ready;
  endtask

  task automatic idle(input int n);
    logic ar, aw;
    repeat (n) tick(1'b0, '0, 1'b0, '0, '0, 1'b0, ar, aw);
  endtask

  task automatic check_outputs_zero();
    check("rst_rd_data", 64'(bus.rd_data), 64'(0));
    check("rst_zbt_write_data", 64'(bus.zbt_write_data), 64'(0));
    check("rst_zbt_addr", 64'(bus.zbt_addr), 64'(0));
    check("rst_ctrl", 64'({bus.rd_valid, bus.zbt_we, bus.clear_busy, bus.rd_ready, bus.wr_ready}), 64'(0));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.clear_start = 1'b0;
    iss_q.delete(); wd_q.delete(); rd_q.delete();
    m_last_win_wr = 1'b1;
    m_clr = 1'b0;
    #1;
    check_outputs_zero();
    repeat (3) @(negedge clk);
    check_outputs_zero();
    rst_n = 1'b1;
  endtask

  logic          ar, aw, rq, wq;
  logic [AW-1:0] ra, wa;
  logic [DW-1:0] wdv, v;
  int nr, nw, exp_r, n_busy, acc_t;

  initial begin
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.wr_req = 1'b0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.clear_start = 1'b0; bus.zbt_read_data = '0;
    for (int i = 0; i < 32; i++) begin
      v = DW'({$urandom(), $urandom()}) | DW'(1);
      sram[AW'(i)] = v;
      ref_mem[AW'(i)] = v;
    end
    sram[AW'('h10)] = 36'h123456789;
    ref_mem[AW'('h10)] = 36'h123456789;

    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero();
    rst_n = 1'b1;

    // single read, then single write and its read-back
    tick(1'b1, AW'('h10), 1'b0, '0, '0, 1'b0, ar, aw);
    idle(4);
    tick(1'b0, '0, 1'b1, AW'('h200), DW'('hABCDE), 1'b0, ar, aw);
    idle(3);
    tick(1'b1, AW'('h200), 1'b0, '0, '0, 1'b0, ar, aw);
    idle(4);

    // both sides held for 8 cycles
    nr = 0; nw = 0;
    wa = AW'('h400); wdv = DW'('h5000);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, AW'(32 + i), 1'b1, wa, wdv, 1'b0, ar, aw);
      if (ar) nr++;
      if (aw) begin nw++; wa = wa + AW'(1); wdv = wdv + DW'(1); end
    end
`ifdef ZBT_READ_PRIORITY_EN
    exp_r = 8;
`else
    exp_r = 4;
`endif
    check("contend_reads", 64'(nr), 64'(exp_r));
    check("contend_writes", 64'(nw), 64'(8 - exp_r));
    tick(1'b0, '0, 1'b1, wa, wdv, 1'b0, ar, aw);
    check("write_after_rd_drop", 64'(aw), 64'(1));
    idle(4);

    // clear engine with a writer waiting; a second clear_start mid-clear is ignored
    tick(1'b0, '0, 1'b1, AW'('h300), DW'('h777), 1'b1, ar, aw);
    wa = AW'('h301); wdv = DW'('h888);
    n_busy = 0; acc_t = -1;
    for (int t = 0; t < 40; t++) begin
      tick(1'b0, '0, 1'b1, wa, wdv, (t == 5), ar, aw);
      if (bus.clear_busy) n_busy++;
      if (aw) begin acc_t = t; break; end
    end
    check("clear_busy_cycles", 64'(n_busy), 64'(CD));
    check("write_after_clear", 64'(acc_t), 64'(CD));
    idle(3);
    for (int i = 0; i < CD + 2; i++) tick(1'b1, AW'(i), 1'b0, '0, '0, 1'b0, ar, aw);
    idle(4);

    // reset one cycle after issuing two reads
    tick(1'b1, AW'(20), 1'b0, '0, '0, 1'b0, ar, aw);
    tick(1'b1, AW'(21), 1'b0, '0, '0, 1'b0, ar, aw);
    apply_reset();
    tick(1'b1, AW'(22), 1'b0, '0, '0, 1'b0, ar, aw);
    idle(4);

    // randomized traffic; requests stay stable until accepted
    rq = 1'b0; wq = 1'b0; ra = '0; wa = '0; wdv = '0;
    ar = 1'b1; aw = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!rq || ar) begin rq = ($urandom_range(0, 2) != 0); ra = AW'($urandom_range(0, 31)); end
      if (!wq || aw) begin
        wq  = ($urandom_range(0, 2) != 0);
        wa  = AW'($urandom_range(0, 31));
        wdv = DW'({$urandom(), $urandom()});
      end
      tick(rq, ra, wq, wa, wdv, ($urandom_range(0, 49) == 0), ar, aw);
    end
    idle(8);
    check("drain_queues", 64'(iss_q.size() + wd_q.size() + rd_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/zbt_port_arbiter.md
Name: zbt_port_arbiter

Overview:
- Shares the single ZBT0 SRAM port between two requesters: the point-capture writer (x/y samples from the scanner) and the display renderer's read path.
- Issues at most one SRAM operation per cycle with round-robin arbitration.
- Aligns pipelined write data and read-return data to the ZBT two-cycle latency.
- Contains an internal clear engine that zero-fills a memory region before a new scan.

Parameters:
- ADDR_W, 19, SRAM address width.
- DATA_W, 36, SRAM data width.
- RD_LATENCY, 2, cycles from address issue edge to the read-data capture edge.
- WR_LATENCY, 2, cycles from address issue edge until zbt_write_data must carry the write data.
- CLEAR_DEPTH, 2**19, number of words zeroed by the clear engine (addresses 0..CLEAR_DEPTH-1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_req  in  1  writer has a valid request; addr/data held stable until accepted.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  combinational; write is accepted on the edge where wr_req && wr_ready.
- rd_req  in  1  renderer has a valid read request.
- rd_addr  in  ADDR_W  read address.
- rd_ready  out  1  combinational; read is accepted on the edge where rd_req && rd_ready.
- rd_data  out  DATA_W  read return data.
- rd_valid  out  1  one-cycle pulse per accepted read, in order.
- clear_start  in  1  pulse; starts the clear engine (ignored while clear_busy).
- clear_busy  out  1  high while the clear engine is running.
- zbt_addr  out  ADDR_W  registered SRAM address.
- zbt_we  out  1  registered, active-high write enable (pin-level inversion is done outside this block).
- zbt_write_data  out  DATA_W  write data, delayed WR_LATENCY cycles after its address.
- zbt_read_data  in  DATA_W  SRAM read data.

Behaviour:
Reset values:
- All outputs are 0.
- Data/valid pipelines are flushed.
- Round-robin pointer favours read.
- Clear FSM is in IDLE.

Reset behaviour:
- Reset mid-operation discards in-flight reads and writes: no rd_valid pulse is produced for them.

Requesters and grants:
- Three requesters: read (R), external write (W), clear write (C).
- C replaces W while clear_busy: wr_ready = 0 throughout the clear.
- Each cycle at most one of rd_ready / wr_ready / internal clear grant is high.

Arbitration:
- Round-robin between the read side and the write side (W, or C during a clear).
- On contention, grant the side not granted on the most recent contended cycle.
- An uncontested requester is granted immediately; it does not wait for its turn.
- Reset state: read wins the first contention.

Issue:
- On an accept edge, register zbt_addr and set zbt_we = 1 for writes, 0 for reads.
- Idle cycle: zbt_we = 0 and zbt_addr holds its previous value.

Write data path:
- Accepted write data shifts through a WR_LATENCY-stage pipeline.
- zbt_write_data presents it WR_LATENCY cycles after zbt_addr/zbt_we; otherwise it holds 0.

Read return path:
- A read-tag shift register of depth RD_LATENCY follows each read.
- When the tag emerges, rd_data <= zbt_read_data and rd_valid pulses for one cycle.
- Back-to-back reads give back-to-back rd_valid; data is never reordered.

Clear FSM (IDLE -> CLEAR -> IDLE):
- clear_start in IDLE: counter <= 0, clear_busy <= 1.
- In CLEAR: each granted slot writes 0 to the counter address, then counter increments.
- After address CLEAR_DEPTH-1 is issued: return to IDLE and drop clear_busy on the next edge.
- clear_start during CLEAR is ignored.
- The counter is ADDR_W+1 bits wide so CLEAR_DEPTH = 2**ADDR_W terminates without wrap.

Other rules:
- No bus turnaround cycles: ZBT allows read-write-read on consecutive cycles.
- Throughput: 1 operation per cycle whenever any request is pending.

Optional Feature:
- Macro: ZBT_READ_PRIORITY_EN.
- Defined: read always wins contention (strict priority for the real-time display path); writes and clears use only cycles with no rd_req.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset, then rd_req only, rd_addr=0x00010, SRAM model returns 0x123456789 -> rd_ready=1; zbt_addr=0x00010, zbt_we=0 one edge later; rd_valid with rd_data=0x123456789 exactly RD_LATENCY=2 cycles after issue.
2. wr_req only, wr_addr=0x00200, wr_data=0xABCDE -> zbt_we=1 at 0x00200; zbt_write_data=0xABCDE two cycles later; read-back of 0x00200 returns 0xABCDE.
3. rd_req and wr_req both held high for 8 cycles (no optional macro) -> grants alternate R,W,R,W...; 4 reads and 4 writes issued; zbt_we pattern 0,1,0,1...
4. Same as test 3 with ZBT_READ_PRIORITY_EN defined -> 8 reads issued, wr_ready=0 until rd_req drops, then the write issues on the next cycle.
5. CLEAR_DEPTH=16, clear_start pulse while wr_req is held -> clear_busy high; addresses 0..15 written with 0; wr_ready=0 throughout; clear_busy falls after address 15; the pending write is issued next.
6. Assert rst_n=0 one cycle after issuing two reads -> no rd_valid pulses; all outputs 0; first read after release returns correct data with latency 2.
